// File: rtl/kv_fpu_fmv_ctrl.sv
// +--------------------------------------------------------------------------+
// | kv_fpu_fmv_ctrl: two-requester issue/writeback control for the FPU move  |
// | and sign-inject datapath. Optional round-robin via KV_FPU_FMV_RR_ARB_EN. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module kv_fpu_fmv_ctrl #(
  parameter int FLEN  = 64,
  parameter int TAG_W = 5
) (
  input  logic             core_clk,
  input  logic             core_reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [FLEN-1:0]  req0_op1,
  input  logic [FLEN-1:0]  req0_op2,
  input  logic [2:0]       req0_sew,
  input  logic [5:0]       req0_ex_ctrl,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [FLEN-1:0]  req1_op1,
  input  logic [FLEN-1:0]  req1_op2,
  input  logic [2:0]       req1_sew,
  input  logic [5:0]       req1_ex_ctrl,
  input  logic [TAG_W-1:0] req1_tag,
  input  logic             flush,
  output logic             f1_valid,
  output logic [FLEN-1:0]  f1_op1_data,
  output logic [FLEN-1:0]  f1_op2_data,
  output logic [2:0]       f1_sew,
  output logic [5:0]       f1_ex_ctrl,
  input  logic [FLEN-1:0]  f1_wdata,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [FLEN-1:0]  wb_data,
  output logic [TAG_W-1:0] wb_tag,
  output logic             wb_src,
  output logic             ctrl_idle
);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [FLEN-1:0]    wb_data_q, wb_data_d;
  logic [TAG_W-1:0]   wb_tag_q, wb_tag_d;
  logic               wb_src_q, wb_src_d;
  logic               slot_free;
  logic               grant;
  logic               pick1;

`ifdef KV_FPU_FMV_RR_ARB_EN
  logic ptr_q, ptr_d;

  // Pointer names the preferred requester; the other one wins only if it is alone.
  always_comb begin
    pick1 = ptr_q ? req1_valid : ~req0_valid;
    ptr_d = grant ? ~pick1 : ptr_q;
  end

  always_ff @(posedge core_clk or negedge core_reset_n) begin
    if (!core_reset_n) ptr_q <= 1'b0;
    else               ptr_q <= ptr_d;
  end
`else
  always_comb pick1 = ~req0_valid;
`endif

  always_comb begin
    slot_free   = (state_q == EMPTY) | wb_ready;
    grant       = slot_free & ~flush & (req0_valid | req1_valid);
    req0_ready  = grant & ~pick1;
    req1_ready  = grant & pick1;

    f1_valid    = grant;
    f1_op1_data = '0;
    f1_op2_data = '0;
    f1_sew      = '0;
    f1_ex_ctrl  = '0;
    if (grant) begin
      f1_op1_data = pick1 ? req1_op1     : req0_op1;
      f1_op2_data = pick1 ? req1_op2     : req0_op2;
      f1_sew      = pick1 ? req1_sew     : req0_sew;
      f1_ex_ctrl  = pick1 ? req1_ex_ctrl : req0_ex_ctrl;
    end

    state_d   = state_q;
    wb_data_d = wb_data_q;
    wb_tag_d  = wb_tag_q;
    wb_src_d  = wb_src_q;
    // Flush wins over a pending drain; a handshake completing this cycle still counts.
    if (flush) begin
      state_d = EMPTY;
    end else if (grant) begin
      state_d   = FULL;
      wb_data_d = f1_wdata;
      wb_tag_d  = pick1 ? req1_tag : req0_tag;
      wb_src_d  = pick1;
    end else if (wb_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge core_clk or negedge core_reset_n) begin
    if (!core_reset_n) begin
      state_q   <= EMPTY;
      wb_data_q <= '0;
      wb_tag_q  <= '0;
      wb_src_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wb_data_q <= wb_data_d;
      wb_tag_q  <= wb_tag_d;
      wb_src_q  <= wb_src_d;
    end
  end

  assign wb_valid  = (state_q == FULL);
  assign wb_data   = wb_data_q;
  assign wb_tag    = wb_tag_q;
  assign wb_src    = wb_src_q;
  assign ctrl_idle = (state_q == EMPTY) & ~req0_valid & ~req1_valid;

endmodule

`default_nettype wire

// File: doc/kv_fpu_fmv_ctrl.md
KV_FPU_FMV_CTRL -- requirements
Module: kv_fpu_fmv_ctrl

Interface
REQ-001 SHALL have parameter FLEN, default 64, the floating-point register width forwarded to the move/sign-inject datapath.
REQ-002 SHALL have parameter TAG_W, default 5, the width of the destination tag carried alongside each operation.
REQ-003 SHALL have port core_clk, input, 1 bit: the single clock.
REQ-004 SHALL have port core_reset_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have ports req0_valid/req1_valid, input, 1 bit each: requester i has an operation.
REQ-006 SHALL have ports req0_ready/req1_ready, output, 1 bit each: requester i's operation is accepted this cycle.
REQ-007 SHALL have ports reqi_op1, reqi_op2, input, 64 bits each: operands.
REQ-008 SHALL have ports reqi_sew, input, 3 bits: one-hot {64,32,16}.
REQ-009 SHALL have ports reqi_ex_ctrl, input, 6 bits: FPU sub-opcode.
REQ-010 SHALL have ports reqi_tag, input, TAG_W bits: destination tag.
REQ-011 SHALL have port flush, input, 1 bit: kill the held result and block any grant this cycle.
REQ-012 SHALL have ports f1_valid, f1_op1_data, f1_op2_data, f1_sew and f1_ex_ctrl, outputs of 1/64/64/3/6 bits, driving the datapath.
REQ-013 SHALL have port f1_wdata, input, 64 bits: the combinational datapath result.
REQ-014 SHALL have ports wb_valid, output, 1 bit, and wb_ready, input, 1 bit: result handshake.
REQ-015 SHALL have ports wb_data (64 bits), wb_tag (TAG_W bits) and wb_src (1 bit), outputs: the result, its tag and the index of the requester that issued it.
REQ-016 SHALL have port ctrl_idle, output, 1 bit: no result held and no request pending.

Function
REQ-017 SHALL have two states: EMPTY (no result held) and FULL (result held with wb_valid=1).
REQ-018 SHALL define slot_free = EMPTY | (FULL & wb_ready); a grant is allowed only when slot_free & ~flush.
REQ-019 SHALL assert exactly one reqi_ready per granted cycle, and only when reqi_valid=1.
REQ-020 SHALL drive f1_valid = grant, and drive the f1_* operand fields from the granted requester; all f1_* fields SHALL be zero when there is no grant.
REQ-021 SHALL register f1_wdata, tag and source on grant, giving wb_valid the cycle after acceptance (latency 1) and sustaining one result per cycle while wb_ready=1.
REQ-022 SHALL go from FULL to EMPTY on wb_ready with no new grant, and stay FULL when wb_ready and a new grant occur in the same cycle.
REQ-023 SHALL hold wb_data, wb_tag and wb_src stable while wb_valid=1 and wb_ready=0.
REQ-024 SHALL, when flush=1, enter EMPTY next cycle regardless of wb_ready and grant nothing; a result already completing its handshake in the flush cycle SHALL be considered delivered.
REQ-025 SHALL pass a non-one-hot sew to the datapath unchanged, with the zero result forwarded as returned.
REQ-026 SHALL drive ctrl_idle = EMPTY & ~req0_valid & ~req1_valid.

Reset
REQ-027 SHALL on core_reset_n=0, asynchronously, force EMPTY, wb_valid=0, wb_data=0, wb_tag=0, wb_src=0 and priority pointer=0.
REQ-028 SHALL discard any held result when reset is asserted mid-operation; the first grant is allowed on the first clock edge after deassertion.

Configuration
REQ-029 SHALL, with KV_FPU_FMV_RR_ARB_EN defined, arbitrate round-robin: the pointer names the preferred requester, and the pointer moves to the other requester after each grant.
REQ-030 SHALL, without KV_FPU_FMV_RR_ARB_EN, use fixed priority with requester 0 always winning, and have no pointer flop.

Verification
REQ-031 SHALL check: req0 alone with fsgnj, sew=32, op1=0xFFFFFFFF3F800000, op2=0xFFFFFFFFBF800000, tag=3 -> next cycle wb_valid=1, wb_data=0xFFFFFFFFBF800000, wb_tag=3, wb_src=0.
REQ-032 SHALL check: both requesters valid for 4 cycles with wb_ready=1 -> with RR, wb_src sequence 0,1,0,1; without RR, 0,0,0,0.
REQ-033 SHALL check: wb_ready=0 for 3 cycles with both valid -> one result held stable, req0_ready=req1_ready=0, and no f1_valid pulses.
REQ-034 SHALL check: flush together with req0_valid while FULL -> req0_ready=0, next cycle wb_valid=0.
REQ-035 SHALL check: core_reset_n pulsed low while FULL -> wb_valid=0 immediately without waiting for a clock edge, and ctrl_idle=1 once requests drop.
